// File: rtl/branch_seq_if.sv
// Bundle between the control unit and the branch sequencer: decode inputs, the CON FF
// feedback, the datapath strobes and the debug counters.
interface branch_seq_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [31:0]      ir;
  logic             con_out;
  logic [3:0]       c2_field;
  logic             gra;
  logic             r_out;
  logic             con_in;
  logic             pc_out;
  logic             y_in;
  logic             c_out;
  logic             alu_add;
  logic             z_in;
  logic             z_lo_out;
  logic             pc_in;
  logic             busy;
  logic             done;
  logic             taken;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output start, abort, ir, con_out,
    input  c2_field, gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
           z_lo_out, pc_in, busy, done, taken, branch_cnt, taken_cnt
  );

  modport slave (
    input  start, abort, ir, con_out,
    output c2_field, gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
           z_lo_out, pc_in, busy, done, taken, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_seq.sv
// Conditional-branch sequencer: walks T3..T6 around the CON FF, drives registered
// datapath strobes and keeps saturating counts of completed and taken branches.
module branch_seq #(
  parameter int CNT_W   = 16,
  parameter bit FAST_NT = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  branch_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [3:0]       c2_field;
  logic             gra;
  logic             r_out;
  logic             con_in;
  logic             pc_out;
  logic             y_in;
  logic             c_out;
  logic             alu_add;
  logic             z_in;
  logic             z_lo_out;
  logic             pc_in;
  logic             busy;
  logic             done;
  logic             taken;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  // Every output is loaded together with the state it belongs to, so the strobes
  // seen in a cycle are exactly those of the state held in that cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= S_IDLE;
      c2_field   <= 4'd0;
      gra        <= 1'b0;
      r_out      <= 1'b0;
      con_in     <= 1'b0;
      pc_out     <= 1'b0;
      y_in       <= 1'b0;
      c_out      <= 1'b0;
      alu_add    <= 1'b0;
      z_in       <= 1'b0;
      z_lo_out   <= 1'b0;
      pc_in      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      taken      <= 1'b0;
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else begin
      gra      <= 1'b0;
      r_out    <= 1'b0;
      con_in   <= 1'b0;
      pc_out   <= 1'b0;
      y_in     <= 1'b0;
      c_out    <= 1'b0;
      alu_add  <= 1'b0;
      z_in     <= 1'b0;
      z_lo_out <= 1'b0;
      pc_in    <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b1;

      // A flush wins over everything, including the count update of DONE.
      if (bus.abort && (state != S_IDLE)) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              state    <= S_T3;
              c2_field <= bus.ir[22:19];
              taken    <= 1'b0;
              gra      <= 1'b1;
              r_out    <= 1'b1;
              con_in   <= 1'b1;
            end else begin
              busy <= 1'b0;
            end
          end
          S_T3: begin
            state  <= S_T4;
            pc_out <= 1'b1;
            y_in   <= 1'b1;
          end
          S_T4: begin
            taken <= bus.con_out;
            if (FAST_NT && !bus.con_out) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_T5;
              c_out   <= 1'b1;
              alu_add <= 1'b1;
              z_in    <= 1'b1;
            end
          end
          S_T5: begin
            state <= S_T6;
            // The new PC only lands when CON was set; otherwise T6 is an idle slot.
            if (taken) begin
              z_lo_out <= 1'b1;
              pc_in    <= 1'b1;
            end
          end
          S_T6: begin
            state <= S_DONE;
            done  <= 1'b1;
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (branch_cnt != CNT_MAX) begin
              branch_cnt <= branch_cnt + CNT_ONE;
            end
            if (taken && (taken_cnt != CNT_MAX)) begin
              taken_cnt <= taken_cnt + CNT_ONE;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.c2_field   = c2_field;
  assign bus.gra        = gra;
  assign bus.r_out      = r_out;
  assign bus.con_in     = con_in;
  assign bus.pc_out     = pc_out;
  assign bus.y_in       = y_in;
  assign bus.c_out      = c_out;
  assign bus.alu_add    = alu_add;
  assign bus.z_in       = z_in;
  assign bus.z_lo_out   = z_lo_out;
  assign bus.pc_in      = pc_in;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.taken      = taken;
  assign bus.branch_cnt = branch_cnt;
  assign bus.taken_cnt  = taken_cnt;

endmodule
